// File: rtl/pilha_arbiter.sv
// Round-robin arbiter sharing the push/pop stack between the UC and the ULA.
// Optional build macro PILHA_ARB_TOS_CHECK_EN adds a sticky stack-pointer consistency check.
module pilha_arbiter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_uc_req,
  input  logic             i_uc_op,
  input  logic [WIDTH-1:0] i_uc_din,
  output logic             o_uc_ack,
  output logic [WIDTH-1:0] o_uc_dout,
  input  logic             i_ula_req,
  input  logic             i_ula_op,
  input  logic [31:0]      i_ula_din,
  output logic             o_ula_ack,
  output logic [WIDTH-1:0] o_ula_dout,
  output logic             o_stk_en,
  output logic             o_stk_wren,
  output logic             o_stk_sel,
  output logic [31:0]      o_stk_din,
  input  logic [WIDTH-1:0] i_stk_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
`ifdef PILHA_ARB_TOS_CHECK_EN
  ,
  input  logic [15:0]      i_stk_tos,
  output logic             o_tos_err
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_depth;
  logic             r_rr_last;  // 0=UC, 1=ULA
  logic             r_grant;
  logic             r_op;
  logic             r_refused;
  logic [31:0]      r_data;
  logic [WIDTH-1:0] r_uc_dout;
  logic [WIDTH-1:0] r_ula_dout;

  logic             w_any_req;
  logic             w_grant;
  logic             w_op;
  logic [31:0]      w_data;
  logic             w_refuse;

  assign o_full    = (r_depth == CNT_W'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign w_any_req = i_uc_req | i_ula_req;
  // On a tie the requester that did not win last time goes first
  assign w_grant   = (i_uc_req && i_ula_req) ? ~r_rr_last : i_ula_req;
  assign w_op      = w_grant ? i_ula_op : i_uc_op;
  assign w_data    = w_grant ? i_ula_din : 32'(i_uc_din);
  assign w_refuse  = w_op ? o_full : o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_next = w_refuse ? StDone : StIssue;
      StIssue: w_state_next = r_op ? StDone : StWait;
      StWait:  w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_stk_en   = 1'b0;
    o_stk_wren = 1'b0;
    o_stk_sel  = 1'b0;
    o_stk_din  = '0;
    o_uc_ack   = 1'b0;
    o_ula_ack  = 1'b0;
    o_err      = 1'b0;
    unique case (r_state)
      StIssue: begin
        o_stk_en   = 1'b1;
        o_stk_wren = r_op;
        o_stk_sel  = r_grant;
        o_stk_din  = r_data;
      end
      StDone: begin
        o_uc_ack  = ~r_grant;
        o_ula_ack = r_grant;
        o_err     = r_refused;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_depth    <= '0;
      r_rr_last  <= 1'b1;
      r_grant    <= 1'b0;
      r_op       <= 1'b0;
      r_refused  <= 1'b0;
      r_data     <= '0;
      r_uc_dout  <= '0;
      r_ula_dout <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_grant   <= w_grant;
            r_op      <= w_op;
            r_data    <= w_data;
            r_refused <= w_refuse;
            r_rr_last <= w_grant;
          end
        end
        StIssue: r_depth <= r_op ? r_depth + CNT_W'(1) : r_depth - CNT_W'(1);
        StWait: begin
          if (r_grant) r_ula_dout <= i_stk_dout;
          else         r_uc_dout  <= i_stk_dout;
        end
        default: ;
      endcase
    end
  end

  assign o_uc_dout  = r_uc_dout;
  assign o_ula_dout = r_ula_dout;

`ifdef PILHA_ARB_TOS_CHECK_EN
  logic r_tos_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tos_err <= 1'b0;
    end else if (r_state == StDone && !r_refused && i_stk_tos != 16'(r_depth)) begin
      r_tos_err <= 1'b1;
    end
  end

  assign o_tos_err = r_tos_err;
`endif

endmodule
